// File: rtl/sub_seq_pkg.sv
// Shared constants for the digit-serial subtractor: FSM state codes and digit-count helpers.
package sub_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int num_digits(input int n, input int k);
        return n / k;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n, input int k);
        return (n / k > 1) ? $clog2(n / k) : 1;
    endfunction

endpackage

// File: rtl/sub_seq_h_sub.sv
// K-bit combinational digit subtractor: diff_d = a_d - b_d - borrow_in.
// The extra top bit of the widened difference is the digit borrow-out.
module h_sub #(
    parameter int K = 2
) (
    input  logic [K-1:0] a_d,
    input  logic [K-1:0] b_d,
    input  logic         borrow_in,
    output logic [K-1:0] diff_d,
    output logic         borrow_out
);

    logic [K:0] full;

    assign full       = {1'b0, a_d} - {1'b0, b_d} - {{K{1'b0}}, borrow_in};
    assign diff_d     = full[K-1:0];
    assign borrow_out = full[K];

endmodule

// File: rtl/sub_seq.sv
// Digit-serial subtractor computing a - b - b_in, K bits per cycle, LSD first.
// Optional SUB_SEQ_SAT_EN: saturate diff to the signed limit when ovf is set.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf
);

    localparam int ND = num_digits(N, K);
    localparam int CW = cnt_width(N, K);

    logic [1:0]    state;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  diff_r;
    logic          borrow;
    logic          b_out_r;
    logic          ovf_r;
    logic [CW-1:0] cnt;

    logic [K-1:0]  a_d;
    logic [K-1:0]  b_d;
    logic [K-1:0]  diff_d;
    logic          borrow_d;
    logic          last;
    logic          raw_ovf;

    assign a_d  = a_r[int'(cnt)*K +: K];
    assign b_d  = b_r[int'(cnt)*K +: K];
    assign last = (cnt == CW'(ND - 1));

    // Only meaningful on the last digit, whose top bit is diff[N-1].
    assign raw_ovf = (a_r[N-1] != b_r[N-1]) && (diff_d[K-1] != a_r[N-1]);

    h_sub #(.K(K)) u_h_sub (
        .a_d        (a_d),
        .b_d        (b_d),
        .borrow_in  (borrow),
        .diff_d     (diff_d),
        .borrow_out (borrow_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            diff_r  <= '0;
            borrow  <= 1'b0;
            b_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        borrow <= b_in;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff_r[int'(cnt)*K +: K] <= diff_d;
                    borrow <= borrow_d;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        b_out_r <= borrow_d;
                        ovf_r   <= raw_ovf;
                        state   <= ST_DONE;
`ifdef SUB_SEQ_SAT_EN
                        // Overrides the digit write above with the signed limit.
                        if (raw_ovf)
                            diff_r <= a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign diff      = diff_r;
    assign b_out     = b_out_r;
    assign ovf       = ovf_r;

endmodule
